// File: rtl/sel_mem_seq.sv
// sel_mem_seq: steps the memory selector through 0..NUM_SEL-1 with a programmable dwell,
// then parks it at 0 and pulses done.
module sel_mem_seq #(
    parameter int NUM_SEL = 10,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [DWELL_W-1:0] dwell,
    output logic [3:0]         sel_data,
    output logic               sel_en,
    output logic               busy,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, LOAD, HOLD, DONE} state_t;
    state_t             r_state, w_state_n;
    logic [3:0]         r_idx, w_idx_n;
    logic [DWELL_W-1:0] r_cnt, w_cnt_n, r_dwell_q, w_dwell_q_n;
    logic               w_expire, w_last;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_dwell_q <= DWELL_W'(1);
        end else begin
            r_state   <= w_state_n;
            r_idx     <= w_idx_n;
            r_cnt     <= w_cnt_n;
            r_dwell_q <= w_dwell_q_n;
        end
    end
    // a dwell of one expires straight out of LOAD; otherwise HOLD expires when cnt reaches 1
    assign w_expire = (r_state == LOAD && r_dwell_q == DWELL_W'(1)) ||
                      (r_state == HOLD && r_cnt == DWELL_W'(1));
    assign w_last   = r_idx == 4'(NUM_SEL - 1);
    always_comb begin
        w_state_n   = r_state;
        w_idx_n     = r_idx;
        w_cnt_n     = r_cnt;
        w_dwell_q_n = r_dwell_q;
        case (r_state)
            IDLE: if (start && !abort) begin
                w_state_n   = LOAD;
                w_idx_n     = '0;
                w_dwell_q_n = (dwell == '0) ? DWELL_W'(1) : dwell;
            end
            LOAD, HOLD: begin
                w_cnt_n = (r_state == LOAD) ? r_dwell_q - DWELL_W'(1) : r_cnt - DWELL_W'(1);
                if (abort) w_state_n = DONE;
                else if (w_expire) begin
                    w_state_n = w_last ? DONE : LOAD;
                    w_idx_n   = w_last ? r_idx : r_idx + 4'd1;
                end else w_state_n = HOLD;
            end
            default: w_state_n = IDLE;
        endcase
    end
    assign sel_en   = r_state == LOAD || r_state == DONE;
    assign sel_data = (r_state == LOAD || r_state == HOLD) ? r_idx : 4'd0;
    assign busy     = r_state != IDLE;
    assign done     = r_state == DONE;
endmodule

// File: tb/tb_sel_mem_seq.sv
// tb_sel_mem_seq: directed bench for sel_mem_seq with NUM_SEL=10, DWELL_W=8.
module tb_sel_mem_seq;
    logic       clk = 1'b0, clk_run = 1'b0;
    logic       rst = 1'b0, start = 1'b0, abort = 1'b0;
    logic [7:0] dwell = 8'd0;
    logic [3:0] sel_data;
    logic       sel_en, busy, done;
    int         errors = 0, checks = 0;

    sel_mem_seq #(.NUM_SEL(10), .DWELL_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dwell(dwell),
        .sel_data(sel_data), .sel_en(sel_en), .busy(busy), .done(done)
    );

    always #5 if (clk_run) clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] e_sel, input logic e_en, input logic e_busy, input logic e_done);
        checks++;
        assert ({sel_data, sel_en, busy, done} === {e_sel, e_en, e_busy, e_done})
        else begin
            errors++;
            $error("FAIL %s: got sel=%h en=%b busy=%b done=%b, expected sel=%h en=%b busy=%b done=%b",
                   tag, sel_data, sel_en, busy, done, e_sel, e_en, e_busy, e_done);
        end
    endtask

    // Start a run and check every cycle through the trailing IDLE; perturb pokes start/dwell mid-run.
    task automatic run(input string tag, input int d, input bit perturb);
        int D;
        D = (d == 0) ? 1 : d;
        dwell = 8'(d);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 10 * D + 2; c++) begin
            chk(tag, (c <= 10 * D) ? 4'((c - 1) / D) : 4'd0,
                (c == 10 * D + 1) || (c <= 10 * D && (c - 1) % D == 0),
                c <= 10 * D + 1, c == 10 * D + 1);
            start = perturb && (c == 5 || c == 17);
            if (perturb && c == 5) dwell = 8'd1;
            if (c <= 10 * D + 1) step();
        end
        start = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b1;
        #1 chk("reset_noclk", 4'd0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        clk_run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_hold", 4'd0, 1'b0, 1'b0, 1'b0);
        end

        run("full_d3", 3, 1'b0);
        step();
        run("dwell0", 0, 1'b0);
        step();
        run("ignored_inputs", 3, 1'b1);

        step();
        start = 1'b1;
        abort = 1'b1;
        step();
        chk("start_abort_idle", 4'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        step();
        chk("start_abort_idle2", 4'd0, 1'b0, 1'b0, 1'b0);
        abort = 1'b0;

        dwell = 8'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 23; c++) step();
        chk("abort_pre", 4'd4, 1'b0, 1'b1, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_done", 4'd0, 1'b1, 1'b1, 1'b1);
        step();
        chk("abort_idle", 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("abort_no_sel5", 4'd0, 1'b0, 1'b0, 1'b0);

        dwell = 8'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("rst_pre_hold", 4'd0, 1'b0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 chk("rst_async", 4'd0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        step();
        chk("rst_release", 4'd0, 1'b0, 1'b0, 1'b0);
        dwell = 8'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_load0", 4'd0, 1'b1, 1'b1, 1'b0);
        step();
        chk("restart_hold0", 4'd0, 1'b0, 1'b1, 1'b0);
        step();
        chk("restart_load1", 4'd1, 1'b1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sel_mem_seq.md
# sel_mem_seq

Memory-select sequencer for the autoencoder datapath: it is the writer side of the 4-bit memory selector register, generating the select value and its load strobe. On a start request it steps the select through 0 … NUM_SEL-1 and holds each value for a programmable dwell. It then parks the select at 0 and pulses done. The controller uses it to sweep weight/activation memory banks without hand-sequencing the selector.

## Interface

Parameters:
- NUM_SEL, 10: number of select values issued per run; legal range 1..16.
- DWELL_W, 8: width of the dwell count input and the internal dwell counter.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: run request, sampled only in IDLE.
- abort, input, 1: terminates a run in progress.
- dwell, input, DWELL_W: cycles each select value occupies; latched at start; 0 is treated as 1.
- sel_data, output, 4: select value, wired to the selector register data input.
- sel_en, output, 1: load strobe, wired to the selector register enable.
- busy, output, 1: high from the first LOAD through DONE inclusive.
- done, output, 1: one-cycle pulse at the end of a run, whether completed or aborted.

## Operation

- State machine has four states: IDLE, LOAD, HOLD, DONE. Registered state holds idx (4 bits), cnt (DWELL_W bits) and dwell_q (DWELL_W bits).
- Outputs are Moore outputs, decoded from registered state and idx only.
  - IDLE: sel_en=0, sel_data=0, busy=0, done=0.
  - LOAD: sel_en=1, sel_data=idx, busy=1.
  - HOLD: sel_en=0, sel_data=idx, busy=1.
  - DONE: sel_en=1, sel_data=0 (park), busy=1, done=1.
- IDLE:
  - start=1 and abort=0: dwell_q = max(dwell,1), idx=0, go to LOAD.
  - start and abort both high: stay in IDLE.
- LOAD:
  - cnt = dwell_q-1.
  - If dwell_q=1, treat it as HOLD expiry immediately.
  - Otherwise go to HOLD.
- HOLD: cnt decrements each cycle. Expiry occurs on the cycle cnt=1, so HOLD lasts dwell_q-1 cycles.
- Expiry handling:
  - idx=NUM_SEL-1: go to DONE.
  - Otherwise: idx+1, go to LOAD.
- DONE: go to IDLE unconditionally.
- abort=1 in LOAD or HOLD: go to DONE on the next edge, with no further select values. abort in DONE or IDLE has no effect.
- start while busy is ignored. Changes to dwell mid-run are ignored because dwell_q is frozen.
- idx never exceeds NUM_SEL-1. There is no wrap within a run, and idx restarts at 0 on every start.

## Timing

- Reset values: state=IDLE, idx=0, cnt=0, dwell_q=1, sel_data=0, sel_en=0, busy=0, done=0.
- Reset is asynchronous. Asserting rst in any state forces all of these values without waiting for a clock edge. The block leaves reset into IDLE on the first edge after deassertion.
- start sampled at edge T: the first LOAD is cycle T+1, and the selector register captures 0 at edge T+2.
- Each select value occupies exactly D = max(dwell,1) cycles. sel_en pulses at cycles T+1+k·D for k=0..NUM_SEL-1.
- A full run gives DONE at cycle T+1+NUM_SEL·D. busy is high for NUM_SEL·D+1 cycles.
- Abort latency: abort sampled at edge A puts the block in DONE for cycle A+1, then IDLE at A+2.
- Earliest restart: the next start is accepted at the first IDLE edge after DONE. Back-to-back runs therefore have a one-cycle IDLE gap.

## Test plan

Test parameters are NUM_SEL=10 and DWELL_W=8.

- Reset: pulse rst with no clock running → all outputs 0. Then hold start=0 for 20 cycles → sel_en and busy stay 0.
- Full run, dwell=3, start at T:
  - sel_en=1 at T+1, T+4, …, T+28 with sel_data 0..9.
  - DONE at T+31 with sel_en=1, sel_data=0, done=1.
  - busy high T+1..T+31, IDLE at T+32.
- Dwell 0, treated as 1: sel_en high for 10 consecutive cycles with sel_data 0..9, then done at T+11.
- Abort in HOLD: dwell=5, assert abort while sel_data=4 → next cycle done=1, sel_en=1, sel_data=0, then IDLE. No select 5 is ever issued.
- Ignored inputs during a run: pulse start mid-run and change dwell to 1 mid-run → timing is unchanged from dwell=3. start together with abort in IDLE → stays IDLE.
- Async reset mid-HOLD: assert rst between clock edges → outputs go to 0 immediately. A fresh start after release runs cleanly from sel_data=0.
